// File: rtl/dct2_16_tbuf_if.sv
// Row-in / column-out stream bundle for the 16-point DCT transpose buffer.
// master = producer of rows and consumer of columns; slave = the buffer.
interface dct2_16_tbuf_if #(
  parameter int N     = 16,
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_coef [N];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_col [N];
  logic                    out_first;
  logic                    out_last;

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_col,
    input  out_first, out_last
  );

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_col,
    output out_first, out_last
  );
endinterface

// File: rtl/dct2_16_tbuf.sv
// Ping-pong transpose buffer between the DCT row and column passes.
// Rows are rounded, shifted and clipped on entry; columns stream out.
module dct2_16_tbuf #(
  parameter int N     = 16,
  parameter int IN_W  = 20,
  parameter int OUT_W = 16,
  parameter int SHIFT = 5
) (
  input  logic clk,
  input  logic rst_n,
  dct2_16_tbuf_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic signed [IN_W:0] RND =
    (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAXV =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV =
    {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic [CW-1:0] wr_row;
  logic [CW-1:0] rd_col;
  logic          wr_acc;
  logic          rd_acc;
  logic          ovalid;

  logic signed [IN_W:0]    ext [N];
  logic signed [IN_W:0]    shv [N];
  logic signed [OUT_W-1:0] sat [N];
  logic signed [OUT_W-1:0] mem [2][N][N];

  assign bus.in_ready = !full[wr_sel];
  assign ovalid       = full[rd_sel];
  assign bus.out_valid = ovalid;
  assign bus.out_first = ovalid && (rd_col == '0);
  assign bus.out_last  = ovalid && (rd_col == LAST);
  assign wr_acc = bus.in_valid && !full[wr_sel];
  assign rd_acc = ovalid && bus.out_ready;

  // Round-half-up, floor shift, then clip each incoming coefficient.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ext[i] = $signed({bus.in_coef[i][IN_W-1], bus.in_coef[i]}) + RND;
      shv[i] = ext[i] >>> SHIFT;
      if (shv[i] > MAXV)
        sat[i] = MAXV[OUT_W-1:0];
      else if (shv[i] < MINV)
        sat[i] = MINV[OUT_W-1:0];
      else
        sat[i] = shv[i][OUT_W-1:0];
    end
  end

  // Row write into the bank being filled; storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int c = 0; c < N; c++)
        mem[wr_sel][wr_row][c] <= sat[c];
    end
  end

  // Column read from the bank being drained; zeroed when idle.
  always_comb begin
    for (int r = 0; r < N; r++)
      bus.out_col[r] = ovalid ? mem[rd_sel][r][rd_col] : '0;
  end

  // Bank flags and row/column pointers; the two sides never share a bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      if (wr_acc) begin
        wr_row <= wr_row + 1'b1;
        if (wr_row == LAST) begin
          full[wr_sel] <= 1'b1;
          wr_row       <= '0;
          wr_sel       <= !wr_sel;
        end
      end
      if (rd_acc) begin
        rd_col <= rd_col + 1'b1;
        if (rd_col == LAST) begin
          full[rd_sel] <= 1'b0;
          rd_col       <= '0;
          rd_sel       <= !rd_sel;
        end
      end
    end
  end

endmodule

// File: doc/dct2_16_tbuf.md
Name: dct2_16_tbuf

Overview:
- Transpose buffer between the row pass and the column pass of the 16-point 2-D DCT-II.
- Per cycle, accepts one full first-pass coefficient row of 16 values, ordered Y[0..15]: even outputs from the 8-point even path, odd outputs from the odd adder trees.
- Applies the VVC first-stage rounding shift and 16-bit clip, and stores rows in a ping-pong 16x16 buffer.
- Emits the block column by column to the second-pass dct2_16 row engine.
- Sustains 1 row/cycle in and 1 column/cycle out.

Parameters:
N, 16, transform size (rows per block, coefficients per row); only 16 is supported.
IN_W, 20, input coefficient width (signed).
OUT_W, 16, output coefficient width (signed, after clip).
SHIFT, 5, first-stage right shift (log2(16) + bitDepth 10 - 9); must be >= 1.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_coef holds a valid row.
in_ready  out  1  buffer can accept a row this cycle.
in_coef[0:15]  in  signed IN_W each  first-pass row, index = frequency.
out_valid  out  1  out_col holds a valid column.
out_ready  in  1  consumer accepts column this cycle.
out_col[0:15]  out  signed OUT_W each  column c; element r = stored row r, coefficient c.
out_first  out  1  out_col is column 0 of a block.
out_last  out  1  out_col is column 15 of a block.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - Clears both bank_full flags, wr_sel=0, rd_sel=0, wr_row=0, rd_col=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_first=0, out_last=0, out_col all 0.
  - Storage contents are don't-care and are never exposed while out_valid=0.
- Reset asserted mid-block: all buffered data is discarded. After release, the next accepted row is row 0 of a new block.
- Arithmetic, per element:
  - v = (x + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits with an arithmetic (floor) shift.
  - Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Applied combinationally on the input, before the write.
- Write side:
  - Row accept = in_valid && in_ready.
  - in_ready = !bank_full[wr_sel], derived from registers only.
  - On accept: the row is stored at bank wr_sel, row wr_row; wr_row increments.
  - On accepting row 15: bank_full[wr_sel] <= 1, wr_row <= 0, wr_sel toggles.
  - No partial-block flush; rows always count modulo 16.
- Read side:
  - out_valid = bank_full[rd_sel].
  - out_col[r] = bank rd_sel, row r, column rd_col. Zero when out_valid=0.
  - out_first = out_valid && rd_col==0; out_last = out_valid && rd_col==15.
  - Column accept = out_valid && out_ready; on accept rd_col increments.
  - On accepting column 15: bank_full[rd_sel] <= 0, rd_col <= 0, rd_sel toggles.
  - While out_ready=0, out_col, out_first and out_last stay stable.
- Latency:
  - Column 0 of a block is valid the cycle after its row 15 is accepted.
  - A bank freed by its last column accept is writable the following cycle.
- Simultaneous events:
  - Row-15 write into one bank and column-15 read from the other bank in the same cycle: both flag updates apply.
  - The write never targets the bank being read, because wr_sel != rd_sel whenever both banks are active.
- Boundary condition, both banks full: in_ready=0 until the read bank drains.
- Throughput: with in_valid and out_ready held high, in_ready never drops. Zero bubbles in steady state.

Test Plan:
- DC block:
  - Stimulus: 16 rows each with in_coef[0]=320, others 0; out_ready=1.
  - Response: column 0 = all 10 with out_first=1; columns 1..15 = all 0; out_last on column 15; out_valid rises 1 cycle after row 15.
- Rounding:
  - Stimulus: row 0 holds in_coef[0..3] = {-48, -49, 15, 16}.
  - Response: column c, element 0 = {-1, -2, 0, 1}.
- Saturation:
  - Stimulus: SHIFT=2, in_coef[0]=524287 and in_coef[1]=-524288.
  - Response: column 0 = 32767, column 1 = -32768.
- Streaming:
  - Stimulus: 48 rows back to back, in_valid=1, out_ready=1; element (r,c) = 64*(16*blk + r) + 32*c.
  - Response: in_ready stays 1 throughout; 48 columns are output contiguously; out_col[r] of column c equals 2*(16*blk + r) + c.
- Backpressure:
  - Stimulus: out_ready=0 while 32 rows are offered.
  - Response: in_ready drops after row 31 is accepted; column 0 of block 0 holds stable.
  - Then raise out_ready for 1 cycle: in_ready stays 0 until 16 columns are consumed, then rises the next cycle.
- Reset mid-block:
  - Stimulus: accept 7 rows, pulse rst_n low asynchronously.
  - Response: out_valid=0 immediately, in_ready=1; the next 16 rows form a clean block whose column output matches the DC block scenario.
